// File: rtl/bpb_update_ctrl_if.sv
// Commit-side and BPB-update-side signals of the BPB update controller.
// The controller takes the slave view; the commit stage/BPB side takes the master view.
interface bpb_update_ctrl_if #(
  parameter int IDX_W = 10
);
  logic             commit0_valid;
  logic [IDX_W-1:0] commit0_index;
  logic             commit0_taken;
  logic             commit1_valid;
  logic [IDX_W-1:0] commit1_index;
  logic             commit1_taken;
  logic             commit_ready;
  logic             clear_req;
  logic             update_valid;
  logic [IDX_W-1:0] index_write;
  logic             update_value;
  logic             clear_busy;
  logic             clear_done;

  modport master (
    output commit0_valid, commit0_index, commit0_taken,
    output commit1_valid, commit1_index, commit1_taken,
    output clear_req,
    input  commit_ready, update_valid, index_write, update_value,
    input  clear_busy, clear_done
  );

  modport slave (
    input  commit0_valid, commit0_index, commit0_taken,
    input  commit1_valid, commit1_index, commit1_taken,
    input  clear_req,
    output commit_ready, update_valid, index_write, update_value,
    output clear_busy, clear_done
  );
endinterface

// File: rtl/bpb_update_ctrl.sv
// Serialises two commit slots onto the single BPB write port through a small FIFO,
// and runs a two-pass table sweep (drain, clear, done) on request.
module bpb_update_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 10
) (
  input  logic               clk,
  input  logic               reset,
  bpb_update_ctrl_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             pass_q, pass_d;
  logic             update_valid_q, update_valid_d;
  logic [IDX_W-1:0] index_write_q, index_write_d;
  logic             update_value_q, update_value_d;
  logic             commit_ready_q, commit_ready_d;
  logic             clear_busy_q, clear_busy_d;
  logic             clear_done_q, clear_done_d;

  logic             push0, push1, pop;
  logic [CNT_W-1:0] remain;
  entry_t           e0, e1, head;

  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    sweep_d        = sweep_q;
    pass_d         = pass_q;
    update_valid_d = 1'b0;
    index_write_d  = '0;
    update_value_d = 1'b0;

    push0 = commit_ready_q & bus.commit0_valid;
    push1 = commit_ready_q & bus.commit1_valid;
    pop   = update_valid_q & ((state_q == IDLE) || (state_q == DRAIN));
    e0    = '{idx: bus.commit0_index, taken: bus.commit0_taken};
    e1    = '{idx: bus.commit1_index, taken: bus.commit1_taken};

    if (push0) begin
      mem_d[wr_ptr_d] = e0;
      wr_ptr_d        = wr_ptr_d + PTR_W'(1);
    end
    if (push1) begin
      mem_d[wr_ptr_d] = e1;
      wr_ptr_d        = wr_ptr_d + PTR_W'(1);
    end
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    remain   = cnt_q - CNT_W'(pop);

    // Outputs are registered, so the next head may be an entry being pushed this cycle.
    if (remain != '0) head = mem_q[rd_ptr_d];
    else if (push0)   head = e0;
    else              head = e1;

    unique case (state_q)
      IDLE:  if (bus.clear_req) state_d = DRAIN;
      DRAIN: if (cnt_q == '0)   state_d = CLEAR;
      CLEAR: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == '1) begin
          pass_d = ~pass_q;
          if (pass_q) state_d = DONE;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == CLEAR) begin
      update_valid_d = 1'b1;
      index_write_d  = sweep_d;
    end else if (((state_d == IDLE) || (state_d == DRAIN)) && (cnt_d != '0)) begin
      update_valid_d = 1'b1;
      index_write_d  = head.idx;
      update_value_d = head.taken;
    end

    commit_ready_d = (state_d == IDLE) && (cnt_d <= CNT_W'(FIFO_DEPTH - 2));
    clear_busy_d   = (state_d == DRAIN) || (state_d == CLEAR);
    clear_done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      sweep_q        <= '0;
      pass_q         <= 1'b0;
      update_valid_q <= 1'b0;
      index_write_q  <= '0;
      update_value_q <= 1'b0;
      commit_ready_q <= 1'b0;
      clear_busy_q   <= 1'b0;
      clear_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      sweep_q        <= sweep_d;
      pass_q         <= pass_d;
      update_valid_q <= update_valid_d;
      index_write_q  <= index_write_d;
      update_value_q <= update_value_d;
      commit_ready_q <= commit_ready_d;
      clear_busy_q   <= clear_busy_d;
      clear_done_q   <= clear_done_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.update_valid = update_valid_q;
  assign bus.index_write  = index_write_q;
  assign bus.update_value = update_value_q;
  assign bus.commit_ready = commit_ready_q;
  assign bus.clear_busy   = clear_busy_q;
  assign bus.clear_done   = clear_done_q;

endmodule

// File: tb/tb_bpb_update_ctrl.sv
// Scoreboard bench for bpb_update_ctrl: commit writes are queued when accepted and
// compared in order as the BPB write port produces them; sweep writes are tracked separately.
module tb_bpb_update_ctrl;
  localparam int IDX_W = 10;
  localparam int DEPTH = 4;
  localparam int TBL   = 1 << IDX_W;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bpb_update_ctrl_if #(.IDX_W(IDX_W)) bus ();

  bpb_update_ctrl #(.FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               sweep_cnt = 0;
  logic [IDX_W-1:0] sweep_exp = '0;
  int               done_cnt = 0;
  bit               mon_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset && mon_en) begin
      if (bus.clear_done) done_cnt++;
      if (bus.update_valid) begin
        checks++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if ({bus.index_write, bus.update_value} !== e) begin
            errors++;
            $display("FAIL commit_write: got idx=%0h val=%0b, expected idx=%0h val=%0b",
                     bus.index_write, bus.update_value, e.idx, e.taken);
          end
        end else if (bus.clear_busy) begin
          if (bus.index_write !== sweep_exp || bus.update_value !== 1'b0) begin
            errors++;
            $display("FAIL sweep_write: got idx=%0h val=%0b, expected idx=%0h val=0",
                     bus.index_write, bus.update_value, sweep_exp);
          end
          sweep_exp = sweep_exp + IDX_W'(1);
          sweep_cnt++;
        end else begin
          errors++;
          $display("FAIL unexpected_write: got idx=%0h val=%0b, expected no write",
                   bus.index_write, bus.update_value);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.commit0_valid = 1'b0;
    bus.commit0_index = '0;
    bus.commit0_taken = 1'b0;
    bus.commit1_valid = 1'b0;
    bus.commit1_index = '0;
    bus.commit1_taken = 1'b0;
    bus.clear_req     = 1'b0;
  endtask

  task automatic present(input bit v0, input logic [IDX_W-1:0] i0, input bit t0,
                         input bit v1, input logic [IDX_W-1:0] i1, input bit t1,
                         output bit acc);
    bus.commit0_valid = v0;
    bus.commit0_index = i0;
    bus.commit0_taken = t0;
    bus.commit1_valid = v1;
    bus.commit1_index = i1;
    bus.commit1_taken = t1;
    acc = bus.commit_ready;
    if (acc && v0) exp_q.push_back('{idx: i0, taken: t0});
    if (acc && v1) exp_q.push_back('{idx: i1, taken: t1});
    tick();
    idle_inputs();
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || bus.update_valid) && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.update_valid) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending writes, expected 0", exp_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.update_valid, bus.index_write, bus.update_value, bus.clear_busy,
         bus.clear_done, bus.commit_ready} !== '0) begin
      errors++;
      $display("FAIL %s: got uv=%0b idx=%0h val=%0b busy=%0b done=%0b ready=%0b, expected all 0",
               name, bus.update_valid, bus.index_write, bus.update_value,
               bus.clear_busy, bus.clear_done, bus.commit_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    #12;
    check_outputs_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.commit_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %0b, expected 0", bus.commit_ready);
    end
    tick();
    mon_en = 1'b1;
    checks++;
    if (bus.commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b, expected 1", bus.commit_ready);
    end
  endtask

  task automatic test_single;
    bit acc;
    present(1'b1, 10'd5, 1'b1, 1'b0, '0, 1'b0, acc);
    checks++;
    if ({bus.update_valid, bus.index_write, bus.update_value} !== {1'b1, 10'd5, 1'b1}) begin
      errors++;
      $display("FAIL single_latency: got uv=%0b idx=%0h val=%0b, expected uv=1 idx=5 val=1",
               bus.update_valid, bus.index_write, bus.update_value);
    end
    tick();
    checks++;
    if ({bus.update_valid, bus.index_write, bus.update_value} !== '0) begin
      errors++;
      $display("FAIL single_idle_zero: got uv=%0b idx=%0h val=%0b, expected all 0",
               bus.update_valid, bus.index_write, bus.update_value);
    end
  endtask

  task automatic test_pair;
    bit acc;
    present(1'b1, 10'h3FF, 1'b1, 1'b1, 10'h001, 1'b0, acc);
    checks++;
    if ({bus.update_valid, bus.index_write, bus.update_value} !== {1'b1, 10'h3FF, 1'b1}) begin
      errors++;
      $display("FAIL pair_first: got uv=%0b idx=%0h val=%0b, expected uv=1 idx=3ff val=1",
               bus.update_valid, bus.index_write, bus.update_value);
    end
    tick();
    checks++;
    if ({bus.update_valid, bus.index_write, bus.update_value} !== {1'b1, 10'h001, 1'b0}) begin
      errors++;
      $display("FAIL pair_second: got uv=%0b idx=%0h val=%0b, expected uv=1 idx=1 val=0",
               bus.update_valid, bus.index_write, bus.update_value);
    end
    wait_drain(10);
  endtask

  task automatic test_slot1_only;
    bit acc;
    present(1'b0, 10'h155, 1'b0, 1'b1, 10'h2AA, 1'b1, acc);
    checks++;
    if ({bus.update_valid, bus.index_write, bus.update_value} !== {1'b1, 10'h2AA, 1'b1}) begin
      errors++;
      $display("FAIL slot1_only: got uv=%0b idx=%0h val=%0b, expected uv=1 idx=2aa val=1",
               bus.update_valid, bus.index_write, bus.update_value);
    end
    wait_drain(10);
  endtask

  task automatic test_back_to_back;
    bit acc;
    bit exp_ready;
    bit saw_low = 1'b0;
    int occ = 0;
    int accepted = 0;
    int n = 0;
    while (accepted < 6 && n < 40) begin
      exp_ready = (occ <= DEPTH - 2);
      checks++;
      if (bus.commit_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready: got %0b, expected %0b at occupancy %0d",
                 bus.commit_ready, exp_ready, occ);
      end
      present(1'b1, IDX_W'($urandom), 1'($urandom), 1'b1, IDX_W'($urandom), 1'($urandom), acc);
      if (acc) accepted++;
      else saw_low = 1'b1;
      occ = occ + (exp_ready ? 2 : 0) - ((occ > 0) ? 1 : 0);
      n++;
    end
    checks++;
    if (accepted != 6 || !saw_low) begin
      errors++;
      $display("FAIL b2b_accept: got accepted=%0d ready_dropped=%0b, expected 6 and 1",
               accepted, saw_low);
    end
    wait_drain(20);
  endtask

  task automatic test_clear;
    bit acc;
    int n = 0;
    bit finished = 1'b0;
    sweep_cnt = 0;
    sweep_exp = '0;
    done_cnt  = 0;
    present(1'b1, 10'h011, 1'b1, 1'b1, 10'h022, 1'b0, acc);
    present(1'b1, 10'h033, 1'b1, 1'b1, 10'h044, 1'b1, acc);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    checks++;
    if (bus.clear_busy !== 1'b1 || bus.commit_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_enter: got busy=%0b ready=%0b, expected busy=1 ready=0",
               bus.clear_busy, bus.commit_ready);
    end
    while (!finished && n < 3000) begin
      if (sweep_cnt >= 300 && sweep_cnt < 305) begin
        bus.clear_req     = 1'b1;
        bus.commit0_valid = 1'b1;
        bus.commit0_index = IDX_W'($urandom);
        bus.commit0_taken = 1'b1;
        bus.commit1_valid = 1'b1;
        bus.commit1_index = IDX_W'($urandom);
        bus.commit1_taken = 1'b1;
      end else begin
        idle_inputs();
      end
      tick();
      n++;
      if (bus.clear_done) begin
        finished = 1'b1;
        checks++;
        if (bus.update_valid !== 1'b0 || bus.clear_busy !== 1'b0 || sweep_cnt != 2 * TBL ||
            exp_q.size() != 0) begin
          errors++;
          $display("FAIL clear_done_state: got uv=%0b busy=%0b sweeps=%0d pending=%0d, expected 0 0 %0d 0",
                   bus.update_valid, bus.clear_busy, sweep_cnt, exp_q.size(), 2 * TBL);
        end
      end
    end
    idle_inputs();
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL clear_timeout: got no clear_done after %0d cycles, expected one", n);
    end
    tick();
    checks++;
    if (bus.commit_ready !== 1'b1 || bus.clear_done !== 1'b0 || bus.clear_busy !== 1'b0 ||
        done_cnt != 1) begin
      errors++;
      $display("FAIL clear_exit: got ready=%0b done=%0b busy=%0b pulses=%0d, expected 1 0 0 1",
               bus.commit_ready, bus.clear_done, bus.clear_busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid_clear;
    bit acc;
    int n = 0;
    sweep_cnt = 0;
    sweep_exp = '0;
    done_cnt  = 0;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    while (sweep_cnt < 500 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (bus.update_valid !== 1'b1 || bus.index_write !== 10'd500) begin
      errors++;
      $display("FAIL mid_sweep_index: got uv=%0b idx=%0d, expected uv=1 idx=500",
               bus.update_valid, bus.index_write);
    end
    reset = 1'b0;
    #1;
    check_outputs_zero("reset_mid_clear");
    exp_q.delete();
    #20;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (bus.commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_abort: got %0b, expected 1", bus.commit_ready);
    end
    present(1'b1, 10'h077, 1'b0, 1'b0, '0, 1'b0, acc);
    checks++;
    if ({bus.update_valid, bus.index_write, bus.update_value} !== {1'b1, 10'h077, 1'b0}) begin
      errors++;
      $display("FAIL commit_after_abort: got uv=%0b idx=%0h val=%0b, expected uv=1 idx=77 val=0",
               bus.update_valid, bus.index_write, bus.update_value);
    end
    wait_drain(10);
    repeat (4) tick();
    checks++;
    if (done_cnt != 0 || bus.clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got pulses=%0d busy=%0b, expected 0 0", done_cnt, bus.clear_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_slot1_only();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
